// File: rtl/lenet_layer_sequencer.sv
// -----------------------------------------------------------------------------
// lenet_layer_sequencer
//
// Purpose
//   Top-level layer scheduler for the LeNet accelerator. One accepted start
//   runs the engines in the order conv1 -> conv2 -> conv3 -> fc. While the fc
//   engine runs, the sequencer takes an argmax over the streamed class scores.
//   It then reports the winning class with a single-cycle done pulse.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   request one inference; sampled only in IDLE
//   abort        in   synchronous abort; FSM returns to IDLE on the next cycle
//   stage_done   in   [4] completion pulse per engine ([0]=conv1 .. [3]=fc)
//   fc_valid     in   fc score beat valid
//   fc_data      in   [bitwidth] signed fc score, beats arrive in class order
//   stage_start  out  [4] one-hot, single-cycle start pulse to one engine
//   busy         out  high from the cycle after start until done/error/abort
//   done         out  single-cycle pulse when class_id/max_score are valid
//   class_id     out  [4] argmax index
//   max_score    out  [bitwidth] winning score
//   error        out  single-cycle pulse on a protocol fault or timeout
//   err_stage    out  [2] index of the stage that faulted
//
// Configuration
//   LENET_SEQ_WATCHDOG_EN : when defined, each stage has a cycle counter.
//   A stage that runs TIMEOUT_CYCLES cycles without its done raises error.
//   When the macro is undefined, a stage waits indefinitely.
// -----------------------------------------------------------------------------
module lenet_layer_sequencer #(
  parameter int bitwidth       = 16,
  parameter int NUM_CLASSES    = 10,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [3:0]                 stage_done,
  input  logic                       fc_valid,
  input  logic signed [bitwidth-1:0] fc_data,
  output logic [3:0]                 stage_start,
  output logic                       busy,
  output logic                       done,
  output logic [3:0]                 class_id,
  output logic signed [bitwidth-1:0] max_score,
  output logic                       error,
  output logic [1:0]                 err_stage
);

  typedef enum logic [2:0] {IDLE, S_C1, S_C2, S_C3, S_FC, FIN} state_t;

  localparam int              CNT_W    = $clog2(NUM_CLASSES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CLASSES);

  state_t                     state;
  logic [CNT_W-1:0]           beat_cnt;
  logic [CNT_W-1:0]           cnt_next;
  logic signed [bitwidth-1:0] run_max;
  logic signed [bitwidth-1:0] win_max;
  logic [3:0]                 run_idx;
  logic [3:0]                 win_idx;
  logic [1:0]                 stage_idx;
  logic                       in_stage;
  logic                       stage_fire;
  logic                       beat_take;
  logic                       beat_wins;

`ifdef LENET_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expired;
  // wd_cnt is cleared on stage entry. It therefore reads TIMEOUT_CYCLES-1
  // on the last cycle the stage is allowed to run.
  assign wd_expired = in_stage && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    in_stage  = 1'b0;
    stage_idx = 2'd0;
    case (state)
      S_C1:    begin in_stage = 1'b1; stage_idx = 2'd0; end
      S_C2:    begin in_stage = 1'b1; stage_idx = 2'd1; end
      S_C3:    begin in_stage = 1'b1; stage_idx = 2'd2; end
      S_FC:    begin in_stage = 1'b1; stage_idx = 2'd3; end
      default: ;
    endcase
    // The own stage_start pulse marks the entry cycle.
    // A stage_done on that cycle belongs to an earlier run and is ignored.
    stage_fire = in_stage && stage_done[stage_idx] && !stage_start[stage_idx];

    // Beats past NUM_CLASSES are dropped. Beat 0 always seeds the running max.
    // A later beat replaces it only if strictly greater, so ties keep the lower index.
    beat_take = (state == S_FC) && fc_valid && (beat_cnt < LAST_CNT);
    beat_wins = beat_take && ((beat_cnt == '0) || (fc_data > run_max));
    cnt_next  = beat_take ? beat_cnt + CNT_W'(1) : beat_cnt;
    // The final beat may arrive together with stage_done[3].
    // The result is therefore taken from the post-beat values.
    win_max   = beat_wins ? fc_data : run_max;
    win_idx   = beat_wins ? 4'(beat_cnt) : run_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      stage_start <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      class_id    <= '0;
      max_score   <= '0;
      error       <= 1'b0;
      err_stage   <= '0;
      beat_cnt    <= '0;
      run_max     <= '0;
      run_idx     <= '0;
`ifdef LENET_SEQ_WATCHDOG_EN
      wd_cnt      <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. A later
      // assignment in this block overrides the pulse defaults below.
      stage_start <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
`ifdef LENET_SEQ_WATCHDOG_EN
      wd_cnt      <= (in_stage && !stage_fire) ? wd_cnt + WD_W'(1) : '0;
`endif
      if (beat_take) begin
        beat_cnt <= cnt_next;
        run_max  <= win_max;
        run_idx  <= win_idx;
      end

      if (abort) begin
        // Abort wins over start and stage_done and emits no pulse.
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state       <= S_C1;
            stage_start <= 4'b0001;
            busy        <= 1'b1;
            class_id    <= '0;
            max_score   <= '0;
            err_stage   <= '0;
            beat_cnt    <= '0;
          end
          S_C1: if (stage_fire) begin
            state       <= S_C2;
            stage_start <= 4'b0010;
          end
          S_C2: if (stage_fire) begin
            state       <= S_C3;
            stage_start <= 4'b0100;
          end
          S_C3: if (stage_fire) begin
            state       <= S_FC;
            stage_start <= 4'b1000;
          end
          S_FC: if (stage_fire) begin
            busy <= 1'b0;
            if (cnt_next == LAST_CNT) begin
              state     <= FIN;
              done      <= 1'b1;
              class_id  <= win_idx;
              max_score <= win_max;
            end else begin
              // The fc engine finished before all scores arrived.
              state     <= IDLE;
              error     <= 1'b1;
              err_stage <= 2'd3;
            end
          end
          FIN:     state <= IDLE;
          default: state <= IDLE;
        endcase
`ifdef LENET_SEQ_WATCHDOG_EN
        if (wd_expired && !stage_fire) begin
          state     <= IDLE;
          busy      <= 1'b0;
          error     <= 1'b1;
          err_stage <= stage_idx;
        end
`endif
      end
    end
  end

endmodule
